// File: rtl/line_fill_buffer_pkg.sv
// Shared defaults, AXI4 encodings and FSM state encoding for the line fill buffer.
package line_fill_buffer_pkg;

    localparam int unsigned LFB_LINE_WORDS = 8;
    localparam int unsigned LFB_LINE_B     = 5;

    localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StDone,
        StDrain
    } lfb_state_e;

endpackage

// File: rtl/lfb_wrap_counter.sv
// Maps a beat count onto its line word index for a critical-word-first WRAP burst.
module lfb_wrap_counter
    import line_fill_buffer_pkg::*;
#(
    parameter int unsigned LINE_WORDS = LFB_LINE_WORDS,
    localparam int unsigned IdxW = $clog2(LINE_WORDS)
) (
    input  logic [IdxW-1:0] start_i,
    input  logic [IdxW-1:0] count_i,
    output logic [IdxW-1:0] word_idx_o,
    output logic            last_o
);

    // Truncation to IdxW bits gives the modulo-LINE_WORDS wrap for free.
    assign word_idx_o = start_i + count_i;
    assign last_o     = (count_i == IdxW'(LINE_WORDS - 1));

endmodule

// File: rtl/line_fill_buffer.sv
// Cache line fill buffer: issues one AXI4 WRAP burst per miss and assembles the line.
module line_fill_buffer
    import line_fill_buffer_pkg::*;
#(
    parameter int unsigned LINE_WORDS = LFB_LINE_WORDS,
    parameter int unsigned LINE_B     = LFB_LINE_B
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Enable,
    input  logic [31:0]             ReqAddress,
    output logic [31:0]             LineAddress,
    output logic                    FirstWord,
    output logic [31:0]             CrtData,
    output logic [32*LINE_WORDS-1:0] LineData,
    output logic                    Completed,
    output logic                    Occupied,
    output logic                    Error,
    output logic [31:0]             ARADDR,
    output logic [7:0]              ARLEN,
    output logic [2:0]              ARSIZE,
    output logic [1:0]              ARBURST,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    input  logic [31:0]             RDATA,
    input  logic [1:0]              RRESP,
    input  logic                    RLAST,
    input  logic                    RVALID,
    output logic                    RREADY
);

    localparam int unsigned IdxW     = $clog2(LINE_WORDS);
    localparam logic [31:0] LineMask = ~((32'd1 << LINE_B) - 32'd1);

    lfb_state_e              state_q, state_d;
    logic [31:0]             addr_q, addr_d;
    logic [IdxW-1:0]         count_q, count_d;
    logic [32*LINE_WORDS-1:0] line_q, line_d;
    logic [31:0]             crt_q, crt_d;
    logic                    error_q, error_d;

    logic [IdxW-1:0]         word_idx;
    logic                    last_beat;

    lfb_wrap_counter #(
        .LINE_WORDS (LINE_WORDS)
    ) u_wrap_counter (
        .start_i    (addr_q[2 +: IdxW]),
        .count_i    (count_q),
        .word_idx_o (word_idx),
        .last_o     (last_beat)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = count_q;
        line_d    = line_q;
        crt_d     = crt_q;
        error_d   = error_q;
        ARVALID   = 1'b0;
        RREADY    = 1'b0;
        FirstWord = 1'b0;
        Completed = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (Enable) begin
                    addr_d  = ReqAddress;
                    count_d = '0;
                    error_d = 1'b0;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                ARVALID = 1'b1;
                // An abort seen here still has to finish the address handshake.
                if (ARREADY) begin
                    state_d = Enable ? StData : StDrain;
                end
            end
            StData: begin
                RREADY = 1'b1;
                if (RVALID) begin
                    line_d[32*int'(word_idx) +: 32] = RDATA;
                    count_d = count_q + IdxW'(1);
                    if (count_q == '0) begin
                        FirstWord = 1'b1;
                        crt_d     = RDATA;
                    end
                    if ((RRESP != AXI_RESP_OKAY) || (last_beat != RLAST)) begin
                        error_d = 1'b1;
                    end
                    // An abort on the final beat has nothing left to drain.
                    if (last_beat || RLAST) begin
                        state_d = Enable ? StDone : StIdle;
                    end else if (!Enable) begin
                        state_d = StDrain;
                    end
                end else if (!Enable) begin
                    state_d = StDrain;
                end
            end
            StDone: begin
                Completed = 1'b1;
                if (!Enable) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                RREADY = 1'b1;
                if (RVALID && RLAST) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            count_q <= '0;
            line_q  <= '0;
            crt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            line_q  <= line_d;
            crt_q   <= crt_d;
            error_q <= error_d;
        end
    end

    assign CrtData     = FirstWord ? RDATA : crt_q;
    assign LineData    = line_q;
    assign LineAddress = addr_q & LineMask;
    assign Occupied    = (state_q != StIdle);
    assign Error       = error_q;
    assign ARADDR      = {addr_q[31:2], 2'b00};
    assign ARLEN       = 8'(LINE_WORDS - 1);
    assign ARSIZE      = AXI_SIZE_4B;
    assign ARBURST     = AXI_BURST_WRAP;

endmodule

// File: tb/tb_line_fill_buffer.sv
// Scoreboard bench for line_fill_buffer: a stimulus process plays the cache controller and
// AXI slave, a monitor process checks every AR handshake, FirstWord pulse and completed line.
module tb_line_fill_buffer;

    localparam int LW = 8;

    typedef struct {
        logic [32*LW-1:0] line;
        logic [31:0]      la;
        logic             err;
    } done_t;

    logic                Clk = 1'b0;
    logic                Rst;
    logic                Enable;
    logic [31:0]         ReqAddress;
    logic [31:0]         LineAddress;
    logic                FirstWord;
    logic [31:0]         CrtData;
    logic [32*LW-1:0]    LineData;
    logic                Completed;
    logic                Occupied;
    logic                Error;
    logic [31:0]         ARADDR;
    logic [7:0]          ARLEN;
    logic [2:0]          ARSIZE;
    logic [1:0]          ARBURST;
    logic                ARVALID;
    logic                ARREADY;
    logic [31:0]         RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                RVALID;
    logic                RREADY;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [31:0] exp_ar_q[$];
    logic [31:0] exp_fw_q[$];
    done_t       exp_done_q[$];

    line_fill_buffer dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Enable      (Enable),
        .ReqAddress  (ReqAddress),
        .LineAddress (LineAddress),
        .FirstWord   (FirstWord),
        .CrtData     (CrtData),
        .LineData    (LineData),
        .Completed   (Completed),
        .Occupied    (Occupied),
        .Error       (Error),
        .ARADDR      (ARADDR),
        .ARLEN       (ARLEN),
        .ARSIZE      (ARSIZE),
        .ARBURST     (ARBURST),
        .ARVALID     (ARVALID),
        .ARREADY     (ARREADY),
        .RDATA       (RDATA),
        .RRESP       (RRESP),
        .RLAST       (RLAST),
        .RVALID      (RVALID),
        .RREADY      (RREADY)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_Occupied"},    Occupied,    0);
        check({tag, "_ARVALID"},     ARVALID,     0);
        check({tag, "_RREADY"},      RREADY,      0);
        check({tag, "_FirstWord"},   FirstWord,   0);
        check({tag, "_Completed"},   Completed,   0);
        check({tag, "_Error"},       Error,       0);
        check({tag, "_LineAddress"}, LineAddress, 0);
        check({tag, "_CrtData"},     CrtData,     0);
        check({tag, "_LineData"},    LineData,    0);
    endtask

    // Monitor: consumes expectations whenever the DUT presents an observable event.
    logic        ar_wait = 1'b0;
    logic [31:0] ar_hold = '0;
    logic        comp_prev = 1'b0;

    always @(negedge Clk) begin
        if (!Rst) begin
            if (ARVALID) begin
                if (ar_wait) check("araddr_stable", ARADDR, ar_hold);
                if (ARREADY) begin
                    if (exp_ar_q.size() == 0) begin
                        check("unexpected_ar", ARVALID, 0);
                    end else begin
                        check("ar_fields", {ARADDR, ARLEN, ARSIZE, ARBURST},
                              {exp_ar_q.pop_front(), 8'd7, 3'b010, 2'b10});
                    end
                    ar_wait = 1'b0;
                end else begin
                    ar_wait = 1'b1;
                    ar_hold = ARADDR;
                end
            end else begin
                ar_wait = 1'b0;
            end

            if (FirstWord) begin
                if (exp_fw_q.size() == 0) check("unexpected_firstword", FirstWord, 0);
                else check("crt_data", CrtData, exp_fw_q.pop_front());
            end

            if (Completed && !comp_prev) begin
                if (exp_done_q.size() == 0) begin
                    check("unexpected_completed", Completed, 0);
                end else begin
                    done_t d;
                    d = exp_done_q.pop_front();
                    check("line_data",    LineData,    d.line);
                    check("line_address", LineAddress, d.la);
                    check("done_error",   Error,       d.err);
                end
            end
        end
        comp_prev = Completed;
    end

    // One fill. abort_at: Enable drops after that many beats (0 = never). err_at: beat index
    // answered with SLVERR (-1 = none). rst_at: Rst asserted while presenting that beat
    // (1-based, 0 = never). hold: cycles Enable stays high after Completed.
    task automatic run_fill(input logic [31:0] addr, input int ar_dly, input int gap,
                            input int abort_at, input int err_at, input int rst_at,
                            input int hold);
        logic [31:0]      data [LW];
        logic [32*LW-1:0] line;
        done_t            d;
        int               start;
        int               n;
        int               g;

        start = int'(addr[4:2]);
        line  = '0;
        for (int i = 0; i < LW; i++) begin
            data[i] = $urandom;
            line[32*((start + i) % LW) +: 32] = data[i];
        end

        exp_ar_q.push_back({addr[31:2], 2'b00});
        if (rst_at != 1) exp_fw_q.push_back(data[0]);
        if (abort_at == 0 && rst_at == 0) begin
            d.line = line;
            d.la   = addr & 32'hFFFF_FFE0;
            d.err  = (err_at >= 0);
            exp_done_q.push_back(d);
        end

        Enable     = 1'b1;
        ReqAddress = addr;
        @(posedge Clk); #1;
        check("ar_latency", ARVALID, 1);
        check("err_clear", Error, 0);
        n = 0;
        while (!ARVALID && n < 20) begin
            @(posedge Clk); #1;
            n++;
        end
        if (!ARVALID) begin
            check("ar_timeout", ARVALID, 1);
            Enable = 1'b0;
            return;
        end
        repeat (ar_dly) begin
            @(posedge Clk); #1;
        end
        ARREADY = 1'b1;
        @(posedge Clk); #1;
        ARREADY = 1'b0;

        for (int i = 0; i < LW; i++) begin
            g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
            repeat (g) begin
                @(posedge Clk); #1;
            end
            RVALID = 1'b1;
            RDATA  = data[i];
            RRESP  = (i == err_at) ? 2'b10 : 2'b00;
            RLAST  = (i == LW - 1);
            if (rst_at != 0 && i == rst_at - 1) begin
                Rst = 1'b1;
                @(posedge Clk); #1;
                RVALID = 1'b0;
                RLAST  = 1'b0;
                RRESP  = 2'b00;
                Enable = 1'b0;
                check_reset("midrst");
                Rst = 1'b0;
                return;
            end
            #1;
            if (i == 0) check("fw_latency", FirstWord, 1);
            if (i == LW - 1 && abort_at == 0) check("no_early_done", Completed, 0);
            n = 0;
            while (!RREADY && n < 20) begin
                @(posedge Clk); #1;
                n++;
            end
            if (!RREADY) begin
                check("rready_timeout", RREADY, 1);
                RVALID = 1'b0;
                Enable = 1'b0;
                return;
            end
            @(posedge Clk); #1;
            RVALID = 1'b0;
            RLAST  = 1'b0;
            RRESP  = 2'b00;
            if (i == err_at) check("err_set", Error, 1);
            if (abort_at != 0 && i + 1 == abort_at) Enable = 1'b0;
        end

        if (abort_at == 0) begin
            check("done_latency", Completed, 1);
            repeat (hold) begin
                @(posedge Clk); #1;
                check("rearm_no_ar", ARVALID, 0);
                check("done_hold", Completed, 1);
            end
            Enable = 1'b0;
            @(posedge Clk); #1;
            check("idle_after_done", Occupied, 0);
        end else begin
            check("idle_after_drain", Occupied, 0);
            check("drain_no_done", Completed, 0);
        end
    endtask

    initial begin
        Rst        = 1'b1;
        Enable     = 1'b0;
        ReqAddress = 32'hDEAD_BEEF;
        ARREADY    = 1'b0;
        RVALID     = 1'b0;
        RDATA      = '0;
        RRESP      = 2'b00;
        RLAST      = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check_reset("init");
        Rst = 1'b0;

        run_fill(32'h0000_1008, 0, 0, 0, -1, 0, 0);   // clean fill, critical word 2
        run_fill(32'h0000_2014, 5, 2, 0, -1, 0, 0);   // AR and R backpressure
        run_fill(32'h0000_3004, 1, -1, 3, -1, 0, 0);  // abort after beat 3
        run_fill(32'h0000_401C, 0, 1, 0, 4, 0, 0);    // SLVERR on beat 5
        run_fill(32'h0000_5000, 0, 0, 0, -1, 0, 0);   // error cleared by new request
        run_fill(32'h0000_600C, 2, 1, 0, -1, 4, 0);   // reset at beat 4
        run_fill(32'h0000_7010, 0, 0, 0, -1, 0, 4);   // Enable held through DONE
        for (int k = 0; k < 6; k++) begin
            run_fill($urandom, int'($urandom_range(3, 0)), -1, 0, -1, 0,
                     int'($urandom_range(2, 0)));
        end

        repeat (2) @(posedge Clk);
        #1;
        check("ar_queue_drained",   exp_ar_q.size(),   0);
        check("fw_queue_drained",   exp_fw_q.size(),   0);
        check("done_queue_drained", exp_done_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish before 500000");
        $fatal(1);
    end

endmodule

// File: doc/line_fill_buffer.md
LINE_FILL_BUFFER -- requirements
Module: line_fill_buffer

Interface
REQ-001 Parameter LINE_WORDS, default 8, words per cache line; power of two.
REQ-002 Parameter LINE_B, default 5, lowest line-index address bit (log2 of line bytes).
REQ-003 Clk  input  1  clock; all state changes on rising edge.
REQ-004 Rst  input  1  reset, synchronous, active-high.
REQ-005 Enable  input  1  fill request level from the cache controller; held high until Completed is seen.
REQ-006 ReqAddress  input  32  byte address of the missing word; sampled in IDLE when Enable is high.
REQ-007 LineAddress  output  32  latched ReqAddress with bits [LINE_B-1:0] zeroed.
REQ-008 FirstWord  output  1  one-cycle pulse when the critical (requested) word arrives.
REQ-009 CrtData  output  32  critical word; valid while FirstWord is high and held until the next request.
REQ-010 LineData  output  32*LINE_WORDS  assembled line, word 0 in the least-significant bits.
REQ-011 Completed  output  1  level; high from full-line arrival until Enable falls.
REQ-012 Occupied  output  1  high in every state except IDLE.
REQ-013 Error  output  1  sticky; set by any nonzero RRESP beat, cleared on the next accepted request.
REQ-014 ARADDR 32 / ARLEN 8 / ARSIZE 3 / ARBURST 2 / ARVALID 1  outputs; ARREADY 1 input: AXI4 read-address channel.
REQ-015 RDATA 32 / RRESP 2 / RLAST 1 / RVALID 1  inputs; RREADY 1 output: AXI4 read-data channel.

Function
REQ-016 The FSM SHALL have states IDLE, ADDR, DATA, DONE, DRAIN.
REQ-017 IDLE with Enable=1: latch ReqAddress, clear beat counter, clear Error, and go to ADDR next cycle.
REQ-018 ADDR: ARVALID=1, ARADDR=latched address word-aligned, ARLEN=LINE_WORDS-1, ARSIZE=3'b010, ARBURST=2'b10 (WRAP). ARVALID and ARADDR SHALL stay stable until ARREADY; go to DATA on the cycle after handshake.
REQ-019 DATA: RREADY=1. On each RVALID, write RDATA into word index (start + count) mod LINE_WORDS, where start = address bits [LINE_B-1:2]; count increments.
REQ-020 The beat with count==0 SHALL assert FirstWord combinationally in that cycle, with CrtData=RDATA, and register CrtData.
REQ-021 The beat with count==LINE_WORDS-1, or any beat with RLAST, SHALL transition to DONE; a count/RLAST mismatch sets Error.
REQ-022 DONE: Completed=1; on Enable=0 go to IDLE next cycle; LineData and LineAddress hold.
REQ-023 Enable falling in ADDR or DATA SHALL move the FSM to DRAIN (ADDR only after its handshake); DRAIN keeps RREADY=1 until RLAST, then goes to IDLE; Completed and FirstWord stay 0.
REQ-024 Enable=1 in DONE SHALL NOT start a new fill; a new fill requires Enable=0 for at least one cycle in IDLE.
REQ-025 Latency: ARVALID 1 cycle after request; FirstWord in the same cycle as the first RVALID; Completed 1 cycle after the last beat.
REQ-026 When RVALID and state change coincide, the beat SHALL be consumed before the state change takes effect.

Reset
REQ-027 Rst SHALL force IDLE, counter=0, ARVALID=0, RREADY=0, FirstWord=0, Completed=0, Occupied=0, Error=0, LineAddress=0, CrtData=0, LineData=0.
REQ-028 Rst mid-burst SHALL abandon the transaction immediately; the memory-side AXI reset is held by the same Rst.

Structure
REQ-029 A shared package SHALL hold the LINE_WORDS/LINE_B defaults, the AXI burst/size/resp encodings, and the FSM state encoding.
REQ-030 One sub-module, lfb_wrap_counter, SHALL produce the wrapped word index and the last-beat flag from start and count.

Verification
REQ-031 Clean fill: request 0x0000_1008, ARREADY immediate, 8 beats D0..D7 -> ARADDR=0x1008, ARLEN=7, ARBURST=2; FirstWord with CrtData=D0; D0 lands in word 2; D7 lands in word 1; Completed 1 cycle after beat 8; LineAddress=0x1000.
REQ-032 Backpressure: ARREADY delayed 5 cycles, RVALID gaps of 2 cycles -> ARADDR stable; no duplicate writes; Completed only after the 8th valid beat.
REQ-033 Abort: Enable falls after beat 3 -> DRAIN consumes beats 4..8; Completed never asserts; IDLE after RLAST.
REQ-034 Error: RRESP=2'b10 on beat 5 -> Error=1 after the beat; fill still completes; Error clears on the next request.
REQ-035 Reset mid-burst: Rst at beat 4 -> all outputs at reset values next cycle; a new request then starts cleanly at ADDR.
REQ-036 Re-arm: Enable held high through DONE -> no second ARVALID until Enable has been low for one cycle.
